dm_port_arbiter: RTL

//  Sequences and shares the single-port data memory (DM) between two requesters.

---
 rtl/dm_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter and sequencer for the single-port data memory.
// Port 0 (MEM stage) and port 1 (debug/loader) share DM through a 3-cycle
// IDLE -> ACCESS -> RESP sequence. Port 1 cannot be starved beyond
// STARVE_MAX back-to-back port-0 grants. Out-of-range addresses never
// enable DM and return err=1 with rdata=0.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   m0_req/we/addr/wdata      port 0 request, held until m0_ack
//   m0_ack/rdata/err          port 0 one-cycle response
//   m1_*                      same set for port 1
//   dm_r_en/w_en/addr/wdata   registered DM controls
//   dm_rdata                  DM read data, sampled at the end of ACCESS
module dm_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_WORDS  = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              dm_r_en,
  output logic              dm_w_en,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam int unsigned       CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             sel;
  logic             we_q;
  logic             err_q;

  logic              grant1_c;
  logic              win_we_c;
  logic              win_err_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;
  logic [DATA_W-1:0] resp_data_c;

  // Winner selection: port 0 has priority until port 1 has waited STARVE_MAX grants
  always_comb begin
    grant1_c    = m1_req && (!m0_req || (starve_cnt == CNT_MAX));
    win_we_c    = grant1_c ? m1_we    : m0_we;
    win_addr_c  = grant1_c ? m1_addr  : m0_addr;
    win_wdata_c = grant1_c ? m1_wdata : m0_wdata;
    win_err_c   = (win_addr_c >= ADDR_LIMIT);
    // Writes and rejected accesses return zero data
    resp_data_c = (we_q || err_q) ? '0 : dm_rdata;
  end

  // Sequencer: all DM controls and responses are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      sel        <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      dm_r_en    <= 1'b0;
      dm_w_en    <= 1'b0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      m0_ack     <= 1'b0;
      m0_rdata   <= '0;
      m0_err     <= 1'b0;
      m1_ack     <= 1'b0;
      m1_rdata   <= '0;
      m1_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!m1_req || grant1_c) begin
            starve_cnt <= '0;
          end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
          if (m0_req || m1_req) begin
            sel      <= grant1_c;
            we_q     <= win_we_c;
            err_q    <= win_err_c;
            dm_r_en  <= !win_we_c && !win_err_c;
            dm_w_en  <= win_we_c && !win_err_c;
            dm_addr  <= win_err_c ? '0 : win_addr_c;
            dm_wdata <= (win_we_c && !win_err_c) ? win_wdata_c : '0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          dm_r_en  <= 1'b0;
          dm_w_en  <= 1'b0;
          dm_addr  <= '0;
          dm_wdata <= '0;
          m0_ack   <= !sel;
          m0_rdata <= sel ? '0 : resp_data_c;
          m0_err   <= !sel && err_q;
          m1_ack   <= sel;
          m1_rdata <= sel ? resp_data_c : '0;
          m1_err   <= sel && err_q;
          state    <= RESP;
        end
        RESP: begin
          m0_ack   <= 1'b0;
          m0_rdata <= '0;
          m0_err   <= 1'b0;
          m1_ack   <= 1'b0;
          m1_rdata <= '0;
          m1_err   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
